// File: rtl/bch_error_injector.sv
// Channel-error stage between the BCH encoder and decoder: corrupts one codeword
// per transaction with either a fixed mask or an LFSR-chosen set of distinct bit positions.
module bch_error_injector #(
   parameter int unsigned CW_WIDTH  = 14,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW_WIDTH-1:0] in_codeword,
   input  logic                cfg_random,
   input  logic [7:0]          cfg_num_errors,
   input  logic [CW_WIDTH-1:0] cfg_fixed_mask,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CW_WIDTH-1:0] out_codeword,
   output logic [CW_WIDTH-1:0] out_error_mask,
   output logic [4:0]          out_error_count,
   output logic                busy,
   output logic [1:0]          dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both
   // high; out_valid holds and the outputs stay frozen until out_ready is sampled high.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PICK = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [CW_WIDTH-1:0] cw_q;
   logic [CW_WIDTH-1:0] mask_q;
   logic [CW_WIDTH-1:0] mask_nx;
   logic [4:0]          remaining_q;
   logic [4:0]          remaining_nx;
   logic [15:0]         lfsr_q;
   logic [15:0]         lfsr_step;
   logic [4:0]          n_clamped;
   logic [3:0]          cand;
   logic                cand_taken;
   logic                cand_ok;
   logic [4:0]          pop;

   // Galois form of x^16+x^14+x^13+x^11+1.
   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign cand      = lfsr_q[3:0];
   assign n_clamped = (cfg_num_errors >= 8'(CW_WIDTH)) ? 5'(CW_WIDTH) : cfg_num_errors[4:0];

   always_comb begin
      cand_taken = 1'b0;
      for (int i = 0; i < int'(CW_WIDTH); i++) begin
         if (cand == 4'(i) && mask_q[i]) cand_taken = 1'b1;
      end
   end

   assign cand_ok = (32'(cand) < CW_WIDTH) && !cand_taken;

   always_comb begin
      pop = '0;
      for (int i = 0; i < int'(CW_WIDTH); i++) begin
         pop = pop + 5'(mask_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      mask_nx      = mask_q;
      remaining_nx = remaining_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!cfg_random) begin
                  mask_nx  = cfg_fixed_mask;
                  state_nx = DONE;
               end else if (n_clamped == 5'd0) begin
                  mask_nx  = '0;
                  state_nx = DONE;
               end else begin
                  mask_nx      = '0;
                  remaining_nx = n_clamped;
                  state_nx     = PICK;
               end
            end
         end
         PICK: begin
            if (cand_ok) begin
               for (int i = 0; i < int'(CW_WIDTH); i++) begin
                  if (cand == 4'(i)) mask_nx[i] = 1'b1;
               end
               remaining_nx = remaining_q - 5'd1;
               if (remaining_q == 5'd1) state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The LFSR is never reseeded between codewords, only on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_q        <= '0;
         mask_q      <= '0;
         remaining_q <= '0;
         lfsr_q      <= LFSR_SEED;
      end else begin
         mask_q      <= mask_nx;
         remaining_q <= remaining_nx;
         if (state == IDLE && in_valid) cw_q <= in_codeword;
         if (state == PICK) lfsr_q <= lfsr_step;
      end
   end

   assign out_codeword    = cw_q ^ mask_q;
   assign out_error_mask  = mask_q;
   assign out_error_count = pop;
   assign busy            = (state != IDLE);
   assign dbg_state       = state;

endmodule

// File: tb/tb_bch_error_injector.sv
// Self-checking bench for bch_error_injector: directed scenarios plus randomized
// codewords against a position-picking reference model.
module tb_bch_error_injector;

   localparam int          CW   = 14;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_codeword = '0;
   logic          cfg_random = 1'b0;
   logic [7:0]    cfg_num_errors = '0;
   logic [CW-1:0] cfg_fixed_mask = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_codeword;
   logic [CW-1:0] out_error_mask;
   logic [4:0]    out_error_count;
   logic          busy;
   logic [1:0]    dbg_state;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [15:0]   mdl_lfsr = SEED;
   logic [CW-1:0] exp_q[$];

   bch_error_injector #(.CW_WIDTH(CW), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_codeword(in_codeword), .cfg_random(cfg_random), .cfg_num_errors(cfg_num_errors),
      .cfg_fixed_mask(cfg_fixed_mask), .out_valid(out_valid), .out_ready(out_ready),
      .out_codeword(out_codeword), .out_error_mask(out_error_mask),
      .out_error_count(out_error_count), .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_codeword", 32'(out_codeword), 32'd0);
      check("rst_mask", 32'(out_error_mask), 32'd0);
      check("rst_count", 32'(out_error_count), 32'd0);
      rst = 1'b0;
      mdl_lfsr = SEED;
      exp_q.delete();
   endtask

   // Reference: draw nibbles from the LFSR until n distinct in-range positions are hit.
   task automatic model(input logic rnd, input logic [7:0] nerr, input logic [CW-1:0] fmask,
                        output logic [CW-1:0] mask, output int picks);
      int n, got, p;
      bit taken[16];
      n = (int'(nerr) > CW) ? CW : int'(nerr);
      mask = '0; picks = 0; got = 0;
      foreach (taken[k]) taken[k] = 1'b0;
      if (!rnd) mask = fmask;
      else begin
         while (got < n) begin
            p = int'(mdl_lfsr & 16'h000F);
            mdl_lfsr = (mdl_lfsr >> 1) ^ (mdl_lfsr[0] ? 16'hB400 : 16'h0000);
            picks++;
            if (p < CW && !taken[p]) begin
               taken[p] = 1'b1;
               mask[p] = 1'b1;
               got++;
            end
         end
      end
   endtask

   task automatic run_cw(input logic [CW-1:0] cw, input logic rnd, input logic [7:0] nerr,
                         input logic [CW-1:0] fmask, input int stall, input logic junk,
                         output logic [CW-1:0] got_cw, output logic [CW-1:0] got_mask,
                         output int got_lat);
      logic [CW-1:0] emask, ecw, snap_cw, snap_mask;
      logic [4:0]    snap_cnt;
      int            picks, exp_lat, w, lat;
      model(rnd, nerr, fmask, emask, picks);
      exp_lat = (rnd && nerr != 8'd0) ? 1 + picks : 1;
      exp_q.push_back(cw ^ emask);
      @(negedge clk);
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      check("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_codeword = cw; cfg_random = rnd;
      cfg_num_errors = nerr; cfg_fixed_mask = fmask;
      @(negedge clk);
      in_valid = junk; in_codeword = 14'($urandom); cfg_random = 1'($urandom);
      cfg_num_errors = 8'($urandom); cfg_fixed_mask = 14'($urandom);
      check("in_ready_busy", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 3000) begin @(negedge clk); lat++; end
      got_lat = lat; got_cw = out_codeword; got_mask = out_error_mask;
      check("latency", 32'(lat), 32'(exp_lat));
      ecw = exp_q.pop_front();
      check("codeword", 32'(out_codeword), 32'(ecw));
      check("mask", 32'(out_error_mask), 32'(emask));
      check("count", 32'(out_error_count), 32'($countones(emask)));
      check("xor_rule", 32'(out_codeword ^ cw), 32'(out_error_mask));
      snap_cw = out_codeword; snap_mask = out_error_mask; snap_cnt = out_error_count;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", {4'd0, snap_cw, snap_mask}, {4'd0, out_codeword, out_error_mask});
         check("hold_count", 32'(out_error_count), 32'(snap_cnt));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [CW-1:0] c, m;
      int            l;
      do_reset();
      run_cw(14'h2A55, 1'b0, 8'd0, 14'h0011, 5, 1'b1, c, m, l);
      check("t1_cw", 32'(c), 32'h2A44);
      check("t1_lat", 32'(l), 32'd1);

      do_reset();
      run_cw(14'h0000, 1'b1, 8'd3, 14'h0000, 2, 1'b0, c, m, l);
      check("t2_mask", 32'(m), 32'h0103);
      check("t2_lat", 32'(l), 32'd4);

      do_reset();
      run_cw(14'h0000, 1'b1, 8'd5, 14'h0000, 0, 1'b0, c, m, l);
      check("t3_mask", 32'(m), 32'h1183);
      check("t3_lat", 32'(l), 32'd7);

      run_cw(14'h1234, 1'b1, 8'd0, 14'h3FFF, 1, 1'b0, c, m, l);
      check("t4_n0_mask", 32'(m), 32'h0000);
      check("t4_n0_lat", 32'(l), 32'd1);
      run_cw(14'h0F0F, 1'b1, 8'd200, 14'h0000, 1, 1'b1, c, m, l);
      check("t4_clamp_mask", 32'(m), 32'h3FFF);
      check("t4_clamp_cw", 32'(c), 32'h30F0);

      // Abort a transaction mid-PICK, then the LFSR must restart from the seed.
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; cfg_random = 1'b1; cfg_num_errors = 8'd5; in_codeword = 14'h2222;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("mid_no_valid", 32'(out_valid), 32'd0);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_valid", 32'(out_valid), 32'd0);
      end
      run_cw(14'h0000, 1'b1, 8'd3, 14'h0000, 0, 1'b0, c, m, l);
      check("t5_mask", 32'(m), 32'h0103);
      check("t5_lat", 32'(l), 32'd4);

      for (int i = 0; i < 100; i++) begin
         logic [7:0] ne;
         ne = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 16));
         run_cw(14'($urandom), 1'($urandom_range(0, 1)), ne, 14'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c, m, l);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bch_error_injector.md
# bch_error_injector

Channel-error stage of the BCH transmission chain. It sits directly downstream of the BCH encoder and upstream of the BCH decoder. It accepts one 14-bit codeword, builds an error mask (either pseudo-random with a requested error count, or a fixed mask from configuration), and emits the corrupted codeword together with the mask and error count. It implements the GENERATE_ERRORS step of the top-level flow as a stand-alone handshaked block.

## Interface
Parameters:
- CW_WIDTH, 14, codeword width in bits; the position field is 4 bits, so CW_WIDTH ≤ 16.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  codeword available from the encoder.
- in_ready  out  1  block can accept a codeword; high only in IDLE.
- in_codeword  in  CW_WIDTH  encoded codeword.
- cfg_random  in  1  1 = random mask, 0 = fixed mask.
- cfg_num_errors  in  8  requested error count in random mode.
- cfg_fixed_mask  in  CW_WIDTH  mask used in fixed mode.
- out_valid  out  1  result valid.
- out_ready  in  1  decoder accepts the result.
- out_codeword  out  CW_WIDTH  in_codeword XOR mask.
- out_error_mask  out  CW_WIDTH  applied mask.
- out_error_count  out  5  popcount of the applied mask.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, PICK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_codeword, cfg_random, cfg_fixed_mask, and n = min(cfg_num_errors, CW_WIDTH).
  - If cfg_random=0: mask=cfg_fixed_mask, go to DONE.
  - If cfg_random=1 and n=0: mask=0, go to DONE.
  - Otherwise: mask=0, remaining=n, go to PICK.
- PICK, one candidate per cycle:
  - Candidate position p = lfsr[3:0] (current value). The LFSR steps in the same cycle.
  - Accept p if p < CW_WIDTH and mask[p]=0. On accept: set mask[p], remaining−1.
  - Otherwise reject p (no mask change, no count change).
  - When remaining reaches 0 in a cycle, go to DONE on the next edge.
- LFSR: 16-bit Galois, x^16+x^14+x^13+x^11+1.
  - Step: lfsr ← (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances only in PICK. It is not reseeded between codewords, so consecutive codewords receive different patterns.
  - The low nibble covers all 16 values within the LFSR period, so PICK always terminates.
- DONE:
  - out_valid=1; out_codeword, out_error_mask, out_error_count held stable.
  - On out_ready: go to IDLE.
- Arithmetic: all GF(2); the corruption is a bitwise XOR only. out_error_count = popcount(mask) (5 bits, max 16).
- Config inputs are sampled only at accept. Later changes do not affect a codeword in flight.

## Timing
- Reset values (synchronous, next edge with rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - out_codeword=0, out_error_mask=0, out_error_count=0.
  - lfsr=LFSR_SEED.
- Reset has priority over every other event. A reset in PICK or DONE drops the transaction with no output.
- Latency, accept edge to out_valid:
  - Fixed mode or n=0: 1 cycle.
  - Random mode: 1 + (PICK cycles); PICK cycles ≥ n, including rejects.
- AXI-style handshakes: transfer occurs when valid&&ready on a rising edge.
  - out_valid stays high until out_ready is sampled high; outputs must not change while out_valid=1 and out_ready=0.
  - in_ready=0 in PICK and DONE.
- Throughput with out_ready held high: in_ready returns 1 the cycle after the output transfer, giving 2 cycles per codeword minimum in fixed mode.
- Simultaneous in_valid and out_ready: no effect. in_ready is low in DONE, so a new codeword can only be accepted in IDLE.
- cfg_num_errors ≥ CW_WIDTH: clamped to CW_WIDTH, producing an all-ones mask.

## Test plan
- Reset, fixed mode: in_codeword=14'h2A55, cfg_fixed_mask=14'h0011 → 1 cycle later out_codeword=14'h2A44, count=2; held stable under out_ready=0 for 5 cycles.
- Fresh reset, random mode, n=3, codeword 0:
  - Candidates 1, 0, 8 → mask 14'h0103, count 3.
  - out_valid 4 cycles after accept.
- Fresh reset, random mode, n=5, codeword 0:
  - Candidates 1, 0, 8, 12, 14 (rejected), 7 → mask 14'h1183, count 5.
  - 6 PICK cycles.
- Random mode edge counts:
  - n=0 → mask 0, latency 1.
  - cfg_num_errors=200 → mask 14'h3FFF, count 14.
- Reset mid-PICK, then a fresh n=3 codeword → identical result to scenario 2 (LFSR reseeded); no stray out_valid.
- 100 random codewords with random out_ready stalls → each output satisfies out_codeword ^ in_codeword == mask and popcount == min(n,14); no input transfer occurs outside IDLE.
